// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// MIPS instruction field positions/widths and PC constants.
package instr_fetch_pkg;

  // Fetch unit states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // request outstanding, result will be presented
    ST_DRAIN = 2'd1,  // request outstanding, result will be discarded
    ST_HOLD  = 2'd2   // instruction presented, waiting for decode
  } if_state_e;

  // Instruction field widths
  localparam int OPCODE_W = 6;
  localparam int FUNC_W   = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int IMM_W    = 16;

  // Instruction field LSB positions
  localparam int OPCODE_LSB = 26;
  localparam int RS_LSB     = 21;
  localparam int RT_LSB     = 16;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNC_LSB   = 0;
  localparam int IMM_LSB    = 0;

  // PC constants
  localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INCR     = 32'd4;

  // Force a byte address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/instr_fetch_split.sv
// Combinational breakout of a 32-bit MIPS instruction word into its fields.
module instr_fetch_split
  import instr_fetch_pkg::*;
(
  input  logic [31:0]         instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNC_W-1:0]   func,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [SHAMT_W-1:0]  shamt,
  output logic [IMM_W-1:0]    imm
);

  // rd/shamt/func overlap imm; all views are always driven, decode picks one
  always_comb begin
    opcode = instr[OPCODE_LSB +: OPCODE_W];
    func   = instr[FUNC_LSB   +: FUNC_W];
    rs     = instr[RS_LSB     +: REG_W];
    rt     = instr[RT_LSB     +: REG_W];
    rd     = instr[RD_LSB     +: REG_W];
    shamt  = instr[SHAMT_LSB  +: SHAMT_W];
    imm    = instr[IMM_LSB    +: IMM_W];
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues word reads over req/ack and
// presents the split instruction fields to decode over valid/ready.
// Optional feature macro: IFETCH_PERF_EN adds fetch_count/squash_count.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | read of pc outstanding; result goes to the output register
// ST_DRAIN | read of drain_addr outstanding; result is discarded
// ST_HOLD  | instruction presented (if_valid), waiting for id_ready
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IF_RESET_PC
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [31:0]         imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect,
  input  logic [31:0]         redirect_pc,
  input  logic                id_ready,
  output logic                if_valid,
  output logic [OPCODE_W-1:0] opcode,
  output logic [FUNC_W-1:0]   func,
  output logic [REG_W-1:0]    rs,
  output logic [REG_W-1:0]    rt,
  output logic [REG_W-1:0]    rd,
  output logic [SHAMT_W-1:0]  shamt,
  output logic [IMM_W-1:0]    imm,
  output logic [31:0]         pc_out,
  output logic [31:0]         pc_plus4
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]         fetch_count,
  output logic [31:0]         squash_count
`endif
);

  if_state_e   state;
  if_state_e   state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] drain_addr;
  logic [31:0] instr_q;
  logic [31:0] pc_out_q;
  logic        load_instr;
  logic        capture_drain;

  // Next-state, PC update and state-decoded handshake outputs
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    load_instr    = 1'b0;
    capture_drain = 1'b0;
    imem_req      = 1'b0;
    imem_addr     = pc;
    if_valid      = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_next = word_align(redirect_pc);
          if (!imem_ack) begin
            // keep driving the issued address until the memory answers
            capture_drain = 1'b1;
            state_next    = ST_DRAIN;
          end
        end else if (imem_ack) begin
          load_instr = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
        if (redirect) pc_next = word_align(redirect_pc);
        if (imem_ack) state_next = ST_FETCH;
      end
      ST_HOLD: begin
        if_valid = 1'b1;
        if (redirect) begin
          pc_next    = word_align(redirect_pc);
          state_next = ST_FETCH;
        end else if (id_ready) begin
          pc_next    = pc + PC_INCR;
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FETCH;
    else     state <= state_next;
  end

  // PC, drain address and presented-instruction registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= word_align(RESET_PC);
      drain_addr <= word_align(RESET_PC);
      instr_q    <= '0;
      pc_out_q   <= word_align(RESET_PC);
    end else begin
      pc <= pc_next;
      if (capture_drain) drain_addr <= pc;
      if (load_instr) begin
        instr_q  <= imem_rdata;
        pc_out_q <= pc;
      end
    end
  end

  instr_fetch_split u_split (
    .instr  (instr_q),
    .opcode (opcode),
    .func   (func),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .imm    (imm)
  );

  assign pc_out   = pc_out_q;
  assign pc_plus4 = pc_out_q + PC_INCR;

`ifdef IFETCH_PERF_EN
  // Accepted-instruction and squash counters; every redirect discards work
  // because a request is always outstanding outside HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count  <= '0;
      squash_count <= '0;
    end else begin
      if (if_valid && id_ready && !redirect) fetch_count <= fetch_count + 32'd1;
      if (redirect) squash_count <= squash_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vector table, wrap-around
// instance, mid-request reset, and a randomized run against a
// transaction-level reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // main instance signals
  logic        rst, imem_req, imem_ack, redirect, id_ready, if_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, pc_out, pc_plus4;
  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  // wrap instance signals
  logic        w_rst, w_req, w_ack, w_redirect, w_ready, w_valid;
  logic [31:0] w_addr, w_rdata, w_rpc, w_pc_out, w_pc_plus4;
  logic [5:0]  w_opcode, w_func;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count, squash_count, w_fetch_count, w_squash_count;
`endif

  instr_fetch dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_ready(id_ready), .if_valid(if_valid),
    .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .imm(imm), .pc_out(pc_out), .pc_plus4(pc_plus4)
`ifdef IFETCH_PERF_EN
    , .fetch_count(fetch_count), .squash_count(squash_count)
`endif
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(w_rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(w_ack), .imem_rdata(w_rdata), .redirect(w_redirect),
    .redirect_pc(w_rpc), .id_ready(w_ready), .if_valid(w_valid),
    .opcode(w_opcode), .func(w_func), .rs(w_rs), .rt(w_rt), .rd(w_rd),
    .shamt(w_shamt), .imm(w_imm), .pc_out(w_pc_out), .pc_plus4(w_pc_plus4)
`ifdef IFETCH_PERF_EN
    , .fetch_count(w_fetch_count), .squash_count(w_squash_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // fields derived from the word with plain shifts and masks
  task automatic check_fields(input string tag, input logic [31:0] w, input logic [31:0] pc);
    chk({tag, ".opcode"}, 32'(opcode), w >> 26);
    chk({tag, ".func"},   32'(func),   w & 32'h3F);
    chk({tag, ".rs"},     32'(rs),     (w >> 21) & 32'h1F);
    chk({tag, ".rt"},     32'(rt),     (w >> 16) & 32'h1F);
    chk({tag, ".rd"},     32'(rd),     (w >> 11) & 32'h1F);
    chk({tag, ".shamt"},  32'(shamt),  (w >> 6) & 32'h1F);
    chk({tag, ".imm"},    32'(imm),    w & 32'hFFFF);
    chk({tag, ".pc_out"}, pc_out, pc);
    chk({tag, ".pc_plus4"}, pc_plus4, pc + 32'd4);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_word;
  } vec_t;

  vec_t vt[20];

  // random-phase reference model
  logic [31:0] exp_pc, drain_a, rpc_r;
  logic        exp_valid, squash_pend, nv, ack_r, redir_r, rdy_r;
  logic [31:0] f_cnt, s_cnt;

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    redirect_pc = '0; id_ready = 1'b0;
    w_rst = 1'b1; w_ack = 1'b0; w_rdata = '0; w_redirect = 1'b0;
    w_rpc = '0; w_ready = 1'b0;

    //          ack   rdata          redir rpc        rdy  valid addr       pc         word
    vt[0]  = '{1'b1, 32'h012A_4020, 1'b0, 32'h0,     1'b1, 1'b0, 32'h0,     32'h0,     32'h0};
    vt[1]  = '{1'b0, 32'h0,         1'b0, 32'h0,     1'b1, 1'b1, 32'h0,     32'h0,     32'h012A_4020};
    vt[2]  = '{1'b1, 32'h8C22_0010, 1'b0, 32'h0,     1'b0, 1'b0, 32'h4,     32'h0,     32'h0};
    vt[3]  = '{1'b0, 32'h0,         1'b0, 32'h0,     1'b0, 1'b1, 32'h0,     32'h4,     32'h8C22_0010};
    vt[4]  = vt[3];
    vt[5]  = vt[3];
    vt[6]  = vt[3];
    vt[7]  = vt[3];
    vt[8]  = '{1'b0, 32'h0,         1'b0, 32'h0,     1'b1, 1'b1, 32'h0,     32'h4,     32'h8C22_0010};
    vt[9]  = '{1'b0, 32'h0,         1'b0, 32'h0,     1'b0, 1'b0, 32'h8,     32'h0,     32'h0};
    vt[10] = '{1'b1, 32'h0002_1080, 1'b0, 32'h0,     1'b0, 1'b0, 32'h8,     32'h0,     32'h0};
    vt[11] = '{1'b0, 32'h0,         1'b1, 32'h100,   1'b1, 1'b1, 32'h0,     32'h8,     32'h0002_1080};
    vt[12] = '{1'b0, 32'h0,         1'b0, 32'h0,     1'b0, 1'b0, 32'h100,   32'h0,     32'h0};
    vt[13] = '{1'b0, 32'h0,         1'b1, 32'h200,   1'b0, 1'b0, 32'h100,   32'h0,     32'h0};
    vt[14] = '{1'b0, 32'h0,         1'b0, 32'h0,     1'b0, 1'b0, 32'h100,   32'h0,     32'h0};
    vt[15] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,     1'b0, 1'b0, 32'h100,   32'h0,     32'h0};
    vt[16] = '{1'b1, 32'hDEAD_BEEF, 1'b1, 32'h203,   1'b0, 1'b0, 32'h200,   32'h0,     32'h0};
    vt[17] = '{1'b1, 32'h3C01_ABCD, 1'b0, 32'h0,     1'b0, 1'b0, 32'h200,   32'h0,     32'h0};
    vt[18] = '{1'b0, 32'h0,         1'b0, 32'h0,     1'b1, 1'b1, 32'h0,     32'h200,   32'h3C01_ABCD};
    vt[19] = '{1'b0, 32'h0,         1'b0, 32'h0,     1'b0, 1'b0, 32'h204,   32'h0,     32'h0};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst.if_valid", 32'(if_valid), 32'd0);
    chk("rst.imem_req", 32'(imem_req), 32'd1);
    chk("rst.imem_addr", imem_addr, 32'h0);
    chk("rst.instr", {opcode, rs, rt, imm}, 32'h0);
    rst = 1'b0;

    // directed vector table
    for (int i = 0; i < 20; i++) begin
      if (vt[i].e_valid) begin
        chk($sformatf("vec%0d.if_valid", i), 32'(if_valid), 32'd1);
        chk($sformatf("vec%0d.imem_req", i), 32'(imem_req), 32'd0);
        check_fields($sformatf("vec%0d", i), vt[i].e_word, vt[i].e_pc);
      end else begin
        chk($sformatf("vec%0d.if_valid", i), 32'(if_valid), 32'd0);
        chk($sformatf("vec%0d.imem_req", i), 32'(imem_req), 32'd1);
        chk($sformatf("vec%0d.imem_addr", i), imem_addr, vt[i].e_addr);
      end
      imem_ack = vt[i].ack; imem_rdata = vt[i].rdata; redirect = vt[i].redir;
      redirect_pc = vt[i].rpc; id_ready = vt[i].rdy;
      @(negedge clk);
    end

    // reset while a request is outstanding
    imem_ack = 1'b0; redirect = 1'b0; id_ready = 1'b0;
    chk("midrst.pre_addr", imem_addr, 32'h204);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst.imem_addr", imem_addr, 32'h0);
    chk("midrst.if_valid", 32'(if_valid), 32'd0);
    chk("midrst.imem_req", 32'(imem_req), 32'd1);

    // PC wrap on the second instance
    @(negedge clk);
    w_rst = 1'b0;
    chk("wrap.addr0", w_addr, 32'hFFFF_FFFC);
    w_ack = 1'b1; w_rdata = 32'h2402_0005; w_ready = 1'b1;
    @(negedge clk);
    chk("wrap.valid0", 32'(w_valid), 32'd1);
    chk("wrap.pc_out0", w_pc_out, 32'hFFFF_FFFC);
    chk("wrap.pc_plus4", w_pc_plus4, 32'h0);
    w_ack = 1'b0;
    @(negedge clk);
    chk("wrap.addr1", w_addr, 32'h0);
    w_ack = 1'b1; w_rdata = 32'h0000_0008;
    @(negedge clk);
    chk("wrap.pc_out1", w_pc_out, 32'h0);
    w_ack = 1'b0;
    @(negedge clk);
    chk("wrap.addr2", w_addr, 32'h4);
    w_redirect = 1'b1; w_rpc = 32'h40;
    @(negedge clk);
    w_redirect = 1'b0;
    chk("wrap.drain_addr", w_addr, 32'h4);
`ifdef IFETCH_PERF_EN
    chk("wrap.fetch_count", w_fetch_count, 32'd2);
    chk("wrap.squash_count", w_squash_count, 32'd1);
`endif

    // randomized run against the reference model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_pc = 32'h0; exp_valid = 1'b0; squash_pend = 1'b0; drain_a = 32'h0;
    f_cnt = 32'd0; s_cnt = 32'd0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd.if_valid", 32'(if_valid), 32'(exp_valid));
      chk("rnd.imem_req", 32'(imem_req), 32'(!exp_valid));
      if (exp_valid) check_fields("rnd", mem_word(exp_pc), exp_pc);
      else chk("rnd.imem_addr", imem_addr, squash_pend ? drain_a : exp_pc);

      ack_r   = !exp_valid && ($urandom_range(0, 2) == 0);
      redir_r = ($urandom_range(0, 9) == 0);
      rpc_r   = ($urandom_range(0, 1) == 0) ? ($urandom & 32'h0000_0FFF) : $urandom;
      rdy_r   = ($urandom_range(0, 1) == 1);
      imem_ack = ack_r; imem_rdata = mem_word(imem_addr);
      redirect = redir_r; redirect_pc = rpc_r; id_ready = rdy_r;

      nv = 1'b0;
      if (redir_r) begin
        s_cnt = s_cnt + 32'd1;
        if (!exp_valid && !ack_r) begin
          if (!squash_pend) drain_a = exp_pc;
          squash_pend = 1'b1;
        end else if (!exp_valid && ack_r) begin
          squash_pend = 1'b0;
        end
        exp_pc = rpc_r & ~32'h3;
      end else if (exp_valid) begin
        if (rdy_r) begin
          exp_pc = exp_pc + 32'd4;
          f_cnt  = f_cnt + 32'd1;
        end else begin
          nv = 1'b1;
        end
      end else if (ack_r) begin
        if (squash_pend) squash_pend = 1'b0;
        else nv = 1'b1;
      end
      exp_valid = nv;
      @(negedge clk);
    end
`ifdef IFETCH_PERF_EN
    chk("rnd.fetch_count", fetch_count, f_cnt);
    chk("rnd.squash_count", squash_count, s_cnt);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit of the MIPS core: owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents the split fields of each fetched instruction (opcode, func, rs, rt, rd, shamt, imm) to the decode/control stage under a valid/ready handshake. It supplies the opcode/func pair the controller decodes. It accepts PC redirects from branch/jump resolution and squashes in-flight or held instructions on redirect.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  instruction read request; held high until imem_ack
- imem_addr  out  32  word-aligned read address, stable while imem_req high
- imem_ack  in  1  read complete; imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- redirect  in  1  load redirect_pc as next fetch address, squash current work
- redirect_pc  in  32  target PC; bits [1:0] ignored (treated as 00)
- id_ready  in  1  decode stage accepts the presented instruction this cycle
- if_valid  out  1  instruction fields below are valid
- opcode  out  6  instr[31:26]
- func  out  6  instr[5:0]
- rs / rt / rd  out  5 each  instr[25:21] / [20:16] / [15:11]
- shamt  out  5  instr[10:6]
- imm  out  16  instr[15:0]
- pc_out  out  32  PC of presented instruction
- pc_plus4  out  32  pc_out + 4 (modulo 2^32)

## Operation
- States: FETCH (request outstanding), DRAIN (request outstanding, result to be discarded), HOLD (instruction presented, waiting id_ready).
- Reset: state=FETCH, pc=RESET_PC, instruction register=0, if_valid=0; imem_req=1 from first post-reset cycle, imem_addr=RESET_PC.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: latch imem_rdata and pc into output register, if_valid=1, go HOLD.
- HOLD: imem_req=0, if_valid=1, outputs stable. On id_ready: pc=pc+4, if_valid=0, go FETCH.
- DRAIN: imem_req=1, imem_addr = the address originally issued (unchanged). On imem_ack: drop data, go FETCH with the already-loaded redirect pc.
- redirect has priority over every other event:
  - FETCH, no ack same cycle: pc=redirect_pc, go DRAIN (outstanding request completes then is discarded).
  - FETCH, ack same cycle: data dropped, pc=redirect_pc, go FETCH.
  - HOLD (with or without id_ready): if_valid=0, pc=redirect_pc, go FETCH; held instruction is not counted as accepted.
  - DRAIN: pc=redirect_pc (latest wins), stay DRAIN unless ack, then FETCH.
- PC arithmetic 32-bit, wraps 32'hFFFF_FFFC -> 0.
- Reset asserted mid-request: state returns to FETCH at RESET_PC; any later ack of the abandoned request is not distinguished (memory is reset with the core).

## Timing
- Minimum fetch latency: ack in the cycle imem_req first rises -> if_valid next cycle.
- Throughput with zero-wait memory and id_ready tied high: one instruction per 2 cycles (FETCH, HOLD).
- Redirect in cycle N: new imem_addr driven in cycle N+1 (FETCH) or after drain ack (DRAIN).
- No combinational path from id_ready or redirect to imem_req/imem_addr; all outputs registered or decoded from state.

## Configuration
- IFETCH_PERF_EN defined: adds outputs fetch_count[31:0] (increments on each accepted instruction, if_valid & id_ready & !redirect) and squash_count[31:0] (increments on each cycle redirect is asserted while state≠FETCH-without-outstanding… i.e. any redirect that discards a request or held instruction); both reset to 0, wrap at 2^32.
- Not defined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package: state encoding (FETCH, DRAIN, HOLD), instruction field bit positions, opcode/func width constants, RESET_PC default, PC increment constant 4.
- One sub-module natural: instr_split (combinational instruction-word -> field breakout), reusable by the controller testbench.

## Test plan
- Reset, zero-wait memory, id_ready=1: imem_addr sequence 0x0,0x4,0x8; if_valid every other cycle; opcode/func match words (e.g. 32'h012A4020 -> opcode 0, func 0x20, rs 9, rt 10, rd 8).
- Backpressure: id_ready=0 for 5 cycles in HOLD -> outputs stable, imem_req=0, pc_out unchanged; on id_ready=1 next imem_addr = pc_out+4.
- Redirect in HOLD to 0x100: held instruction dropped, next imem_addr=0x100, pc_out of next valid = 0x100.
- Redirect during 3-cycle-wait fetch to 0x200: imem_addr stays at old address until ack, ack data never presented, then request at 0x200.
- Redirect and ack same cycle, and redirect_pc=0x203: data dropped, next request at 0x200.
- Wrap: RESET_PC=32'hFFFF_FFFC -> second fetch at 0x0; with IFETCH_PERF_EN, fetch_count=2 and squash_count matches redirects applied.
